// File: rtl/dmem_arb.sv
// dmem_arb: two-port arbiter and command sequencer in front of dmem.
// Port C (pipeline LSU) has fixed priority. Port D (debug/loader) takes
// priority after STARVE_LIMIT consecutive refused cycles. The winner's request
// is registered for one cycle. It is then decoded into dmem's one-hot
// load/store enables and answered on the owner's response port.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   c_*_i / c_*_o             core request/grant/response
//   d_*_i / d_*_o             debug request/grant/response
//   c_stall_o                 core request refused this cycle
//   m_*_o, m_ld_data_i        dmem command and load data
module dmem_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        c_req_i,
  input  logic        c_we_i,
  input  logic [2:0]  c_funct3_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_wdata_i,
  output logic        c_gnt_o,
  output logic        c_rvalid_o,
  output logic        c_err_o,
  output logic [31:0] c_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [2:0]  d_funct3_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic        d_err_o,
  output logic [31:0] d_rdata_o,
  output logic        c_stall_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_st_data_o,
  output logic        m_st_en_o,
  output logic        m_sb_en_o,
  output logic        m_sh_en_o,
  output logic        m_sw_en_o,
  output logic        m_lb_en_o,
  output logic        m_lh_en_o,
  output logic        m_lw_en_o,
  output logic        m_lbu_en_o,
  output logic        m_lhu_en_o,
  input  logic [31:0] m_ld_data_i
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // State bits are {cmd_v, owner}; owner 1 = D.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_C = 2'b10,
    BUSY_D = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                d_pri;
  logic                cmd_v;
  logic                owner_d_port;
  logic                legal;
  logic                fire;
  logic [DATA_W-1:0]   ld_data;

  // Combinational grant: C wins ties unless D has starved long enough.
  assign d_pri     = (starve_q == LIMIT);
  assign d_gnt_o   = d_req_i & (~c_req_i | d_pri);
  assign c_gnt_o   = c_req_i & ~d_gnt_o;
  assign c_stall_o = c_req_i & ~c_gnt_o;

  // Next state: capture the winner's command, else drop to IDLE.
  always_comb begin
    state_d  = IDLE;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = '0;
    if (c_gnt_o) begin
      state_d = BUSY_C;
      we_d    = c_we_i;
      f3_d    = c_funct3_i;
      addr_d  = c_addr_i;
      wdata_d = c_wdata_i;
    end else if (d_gnt_o) begin
      state_d = BUSY_D;
      we_d    = d_we_i;
      f3_d    = d_funct3_i;
      addr_d  = d_addr_i;
      wdata_d = d_wdata_i;
    end
    if (d_req_i && !d_gnt_o) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CNT_W'(1);
    end
  end

  // State and command register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      starve_q <= '0;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cmd_v        = state_q[1];
  assign owner_d_port = state_q[0];

  // Legality: size/type combination and natural alignment.
  always_comb begin
    legal = 1'b0;
    case (f3_q)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_q[0];
      3'b010:  legal = (addr_q[1:0] == 2'b00);
      3'b100:  legal = ~we_q;
      3'b101:  legal = ~we_q & ~addr_q[0];
      default: legal = 1'b0;
    endcase
  end

  assign fire = cmd_v & legal;

  // One-hot dmem enables from the registered command.
  assign m_st_en_o  = fire &  we_q;
  assign m_sb_en_o  = fire &  we_q & (f3_q == 3'b000);
  assign m_sh_en_o  = fire &  we_q & (f3_q == 3'b001);
  assign m_sw_en_o  = fire &  we_q & (f3_q == 3'b010);
  assign m_lb_en_o  = fire & ~we_q & (f3_q == 3'b000);
  assign m_lh_en_o  = fire & ~we_q & (f3_q == 3'b001);
  assign m_lw_en_o  = fire & ~we_q & (f3_q == 3'b010);
  assign m_lbu_en_o = fire & ~we_q & (f3_q == 3'b100);
  assign m_lhu_en_o = fire & ~we_q & (f3_q == 3'b101);

  // Address/data only change on a grant, so they hold when idle.
  assign m_addr_o    = addr_q;
  assign m_st_data_o = wdata_q;

  // Response to the owner only; rdata is zero unless a legal load.
  assign ld_data    = (fire && !we_q) ? m_ld_data_i : '0;
  assign c_rvalid_o = cmd_v & ~owner_d_port;
  assign d_rvalid_o = cmd_v &  owner_d_port;
  assign c_err_o    = c_rvalid_o & ~legal;
  assign d_err_o    = d_rvalid_o & ~legal;
  assign c_rdata_o  = c_rvalid_o ? ld_data : '0;
  assign d_rdata_o  = d_rvalid_o ? ld_data : '0;

endmodule

// File: doc/dmem_arb.md
# dmem_arb

Two-port arbiter and command sequencer in front of the single-ported `dmem` block. It shares the data-memory/IO port between the pipeline LSU (port C) and the debug/loader port (port D), and translates RISC-V funct3 load/store codes into `dmem`'s one-hot enables. Each accepted request is registered for one cycle, so `dmem` always sees a stable, single-owner command. Port C has fixed priority; port D has starvation protection.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles D may be refused before it takes priority; legal range 1..15.
- `clk_i  in  1`  clock, rising edge.
- `rst_ni  in  1`  asynchronous active-low reset.
- `c_req_i  in  1`  core request.
- `c_we_i  in  1`  core request type: 1 = store, 0 = load.
- `c_funct3_i  in  3`  core access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `c_addr_i  in  32`  core byte address.
- `c_wdata_i  in  32`  core store data.
- `c_gnt_o  out  1`  core request accepted this cycle (combinational).
- `c_rvalid_o  out  1`  core response valid.
- `c_err_o  out  1`  core response is an error.
- `c_rdata_o  out  32`  core load data.
- `d_req_i`, `d_we_i`, `d_funct3_i`, `d_addr_i`, `d_wdata_i`, `d_gnt_o`, `d_rvalid_o`, `d_err_o`, `d_rdata_o`: same widths and meaning as the C port, for the debug port.
- `c_stall_o  out  1`  `c_req_i & ~c_gnt_o`; feeds the pipeline hazard unit.
- `m_addr_o  out  32`  address to `dmem`.
- `m_st_data_o  out  32`  store data to `dmem`.
- `m_st_en_o`, `m_sb_en_o`, `m_sh_en_o`, `m_sw_en_o`  out  1 each: store enables.
- `m_lb_en_o`, `m_lh_en_o`, `m_lw_en_o`, `m_lbu_en_o`, `m_lhu_en_o`  out  1 each: load enables.
- `m_ld_data_i  in  32`  combinational load data from `dmem`.

## Operation
**Grant (combinational, cycle N)**
- `d_pri = (starve_cnt == STARVE_LIMIT)`.
- If both ports request: D wins when `d_pri`, otherwise C wins.
- A single requester always wins.
- At most one of `c_gnt_o` and `d_gnt_o` is high in any cycle.

**Starvation counter (`starve_cnt`, 4 bits)**
- Increments when `d_req_i & ~d_gnt_o`, saturating at `STARVE_LIMIT`.
- Clears to 0 on `d_gnt_o` or when `d_req_i` is low.

**Command register (state CMD)**
- On the edge ending a granted cycle, the winner's `we`, `funct3`, `addr`, `wdata` and owner ID are captured, and `cmd_v` is set to 1.
- When no grant occurs, `cmd_v` is cleared to 0.

**Decode (cycle N+1, driven from the command register)**
- Applies only while `cmd_v` is 1 and the command is legal.
- Store: `m_st_en_o` = 1, plus `sb`/`sh`/`sw` for funct3 000/001/010.
- Load: exactly one of `lb`/`lh`/`lw`/`lbu`/`lhu` for funct3 000/001/010/100/101.
- Otherwise every enable is 0; `m_addr_o` and `m_st_data_o` hold their last values.

**Illegal command**: any of the following.
- Store with funct3 ∉ {000, 001, 010}.
- Load with funct3 ∈ {011, 110, 111}.
- H/HU access with `addr[0] = 1`.
- W access with `addr[1:0] != 00`.
- Result: all enables 0, so `dmem` is untouched.

**Response (cycle N+1)**
- The owner's `rvalid` = 1 for both loads and stores.
- `rdata` = `m_ld_data_i` for a legal load, otherwise 0.
- `err` = 1 for an illegal command.
- The non-owner's `rvalid`, `err` and `rdata` are 0.

**FSM**: state bits {`cmd_v`, owner}.
- IDLE: `cmd_v` = 0.
- BUSY_C: `cmd_v` = 1, owner C.
- BUSY_D: `cmd_v` = 1, owner D.
- Any state goes to BUSY_C / BUSY_D / IDLE according to this cycle's grant.
- Back-to-back grants give one access per cycle.

## Timing
**Reset**
- All outputs 0, `cmd_v` = 0, `starve_cnt` = 0.
- Reset asserted mid-access drops the registered command: no `rvalid`, no store enable.

**Latency and throughput**
- Grant is in the same cycle as the request.
- `dmem` command and response are one cycle later.
- A store commits in `dmem` on the edge that ends cycle N+1.
- Load data is valid combinationally in cycle N+1.

**Handshake**
- A requester holds `req` and its payload stable until it sees `gnt`.
- After `gnt`, the requester may change payload or drop `req` on the next cycle.
- The arbiter never grants a request it has not registered.

**Simultaneous events**
- A grant in cycle N+1 does not disturb the response for cycle N's command.
- A store from D followed immediately by a load from C at the same address returns the new data: the store commits before C's command cycle.

## Test plan
- Reset, then C load: LW at 0x010 (word 0xDEADBEEF preloaded) → `c_gnt_o` = 1 in cycle 0; `m_lw_en_o` = 1 and `c_rvalid_o` = 1 with `c_rdata_o` = 0xDEADBEEF in cycle 1; no D response.
- C and D both request continuously, STARVE_LIMIT = 4 → C granted in cycles 0–3; D granted in cycle 4 and `c_stall_o` = 1 in cycle 4; counter cleared; pattern repeats.
- D SW 0x12345678 to 0x800, then C LW 0x800 back-to-back → in cycle 2 `c_rdata_o` = 0x12345678, and `io_hex0` on `dmem` = 0x12345678.
- C LH at 0x013, and C store with funct3 = 011 → all `m_*_en_o` = 0, `c_rvalid_o` = 1, `c_err_o` = 1, `c_rdata_o` = 0; memory unchanged.
- C SB 0xAB at 0x020 granted in cycle 0, `rst_ni` low in cycle 1 before the edge → no `m_st_en_o` after reset, no `c_rvalid_o`, byte 0x020 = 0.
- Only D requests, 8 loads → granted every cycle, `d_rvalid_o` every cycle from cycle 1, `starve_cnt` stays 0.
